// File: rtl/analog_spinner_pkg.sv
// analog_spinner_pkg: shared types and helpers for the spinner angle generator
package analog_spinner_pkg;

    typedef enum logic [1:0] {IDLE, RUN_CW, RUN_CCW, REVERSE} spin_state_t;

    function automatic int step_units(input int shift);
        return 1 << shift;
    endfunction

    // Symmetric clamp so a full reversal never overshoots the opposite bound
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] lim;
        logic signed [31:0] s;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        s = a + b;
        return s > lim ? lim : s < -lim ? -lim : s;
    endfunction

endpackage

// File: rtl/analog_spinner_rate_gen.sv
// spin_rate_gen: per-tick motion from the analog stick and the digital buttons
module spin_rate_gen
    import analog_spinner_pkg::*;
#(
    parameter int ACC_W       = 12,
    parameter int MOUSE_SHIFT = 2,
    parameter int DEADZONE    = 16,
    parameter int ANA_SHIFT   = 3,
    parameter int DIG_SLOW    = 4,
    parameter int DIG_FAST    = 1
) (
    input  logic                    clock_40,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic signed [7:0]       ana_x,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_acc,
    output logic signed [ACC_W-1:0] rate
);

    localparam int CNT_W = $clog2(DIG_SLOW + 1) + 1;
    localparam logic signed [ACC_W-1:0] STEP_P = ACC_W'(step_units(MOUSE_SHIFT));

    logic [CNT_W-1:0]        dig_cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    one_btn;
    logic                    dig_fire;
    logic [7:0]              ana_mag;
    logic [7:0]              ana_units;
    logic signed [ACC_W-1:0] ana_pos;
    logic signed [ACC_W-1:0] ana_add;
    logic signed [ACC_W-1:0] dig_add;

    assign one_btn  = btn_left ^ btn_right;
    assign cnt_inc  = dig_cnt + CNT_W'(1);
    // >= lets a freshly lowered limit fire at once on the next tick
    assign dig_fire = one_btn && (cnt_inc >= CNT_W'(btn_acc ? DIG_FAST : DIG_SLOW));
    assign dig_add  = !dig_fire ? '0 : btn_right ? STEP_P : -STEP_P;

    // -128 folds onto -127 so both stick extremes give the same rate
    assign ana_mag   = ana_x[7] ? (ana_x == -8'sd128 ? 8'd127 : 8'(-ana_x)) : 8'(ana_x);
    assign ana_units = ana_mag > 8'(DEADZONE) ? (ana_mag - 8'(DEADZONE)) >> ANA_SHIFT : 8'd0;
    assign ana_pos   = ACC_W'(ana_units);
    assign ana_add   = ana_x[7] ? -ana_pos : ana_pos;

    assign rate = tick ? ana_add + dig_add : '0;

    always_ff @(posedge clock_40 or negedge reset_n) begin
        if (!reset_n)
            dig_cnt <= '0;
        else if (tick)
            dig_cnt <= (one_btn && !dig_fire) ? cnt_inc : '0;
    end

endmodule

// File: rtl/analog_spinner.sv
// analog_spinner: turns mouse, stick and button motion into the 4-bit Kick spinner angle
module analog_spinner
    import analog_spinner_pkg::*;
#(
    parameter int ACC_W       = 12,
    parameter int MOUSE_SHIFT = 2,
    parameter int DEADZONE    = 16,
    parameter int ANA_SHIFT   = 3,
    parameter int DIG_SLOW    = 4,
    parameter int DIG_FAST    = 1
) (
    input  logic              clock_40,
    input  logic              reset_n,
    input  logic              mouse_strobe,
    input  logic signed [8:0] mouse_x,
    input  logic signed [7:0] ana_x,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_acc,
    input  logic              ctc_zc_to_2,
    output logic [3:0]        spin_angle,
    output logic              spin_dir,
    output logic              spin_busy
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [ACC_W-1:0] STEP_P = ACC_W'(step_units(MOUSE_SHIFT));
    localparam logic signed [ACC_W-1:0] STEP_N = -STEP_P;

    spin_state_t             state;
    spin_state_t             state_next;
    logic                    ctc_q;
    logic                    tick;
    logic signed [ACC_W-1:0] pending;
    logic signed [ACC_W-1:0] pending_next;
    logic signed [ACC_W-1:0] rate;
    logic signed [ACC_W-1:0] consumed;
    logic signed [SUM_W-1:0] mouse_add;
    logic signed [SUM_W-1:0] delta;
    logic                    pos_req;
    logic                    neg_req;
    logic                    step_up;
    logic                    step_dn;

    spin_rate_gen #(
        .ACC_W      (ACC_W),
        .MOUSE_SHIFT(MOUSE_SHIFT),
        .DEADZONE   (DEADZONE),
        .ANA_SHIFT  (ANA_SHIFT),
        .DIG_SLOW   (DIG_SLOW),
        .DIG_FAST   (DIG_FAST)
    ) u_rate (
        .clock_40 (clock_40),
        .reset_n  (reset_n),
        .tick     (tick),
        .ana_x    (ana_x),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_acc  (btn_acc),
        .rate     (rate)
    );

    assign pos_req   = pending >= STEP_P;
    assign neg_req   = pending <= STEP_N;
    assign spin_busy = pos_req | neg_req;

    // Step decisions look at pending before this clock's contributions land
    always_comb begin
        state_next = state;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        if (tick) begin
            case (state)
                RUN_CW: begin
                    state_next = pos_req ? RUN_CW : neg_req ? REVERSE : IDLE;
                    step_up    = pos_req;
                end
                RUN_CCW: begin
                    state_next = neg_req ? RUN_CCW : pos_req ? REVERSE : IDLE;
                    step_dn    = neg_req;
                end
                default: begin
                    state_next = pos_req ? RUN_CW : neg_req ? RUN_CCW : IDLE;
                    step_up    = pos_req;
                    step_dn    = neg_req;
                end
            endcase
        end
    end

    assign consumed     = step_up ? STEP_P : step_dn ? STEP_N : '0;
    assign mouse_add    = mouse_strobe ? SUM_W'(mouse_x) : '0;
    assign delta        = mouse_add + SUM_W'(rate) - SUM_W'(consumed);
    assign pending_next = ACC_W'(sat_add(32'(pending), 32'(delta), ACC_W));

    always_ff @(posedge clock_40 or negedge reset_n) begin
        if (!reset_n) begin
            ctc_q      <= 1'b0;
            tick       <= 1'b0;
            state      <= IDLE;
            pending    <= '0;
            spin_angle <= '0;
            spin_dir   <= 1'b0;
        end else begin
            ctc_q   <= ctc_zc_to_2;
            tick    <= ctc_zc_to_2 & ~ctc_q;
            state   <= state_next;
            pending <= pending_next;
            if (step_up | step_dn) begin
                spin_angle <= step_up ? spin_angle + 4'd1 : spin_angle - 4'd1;
                spin_dir   <= step_up;
            end
        end
    end

endmodule

// File: tb/tb_analog_spinner.sv
// tb_analog_spinner: vector table, corner sequences and randomized run against a reference model
module tb_analog_spinner;

    logic              clock_40 = 1'b0;
    logic              reset_n = 1'b0;
    logic              mouse_strobe = 1'b0;
    logic signed [8:0] mouse_x = '0;
    logic signed [7:0] ana_x = '0;
    logic              btn_left = 1'b0;
    logic              btn_right = 1'b0;
    logic              btn_acc = 1'b0;
    logic              ctc_zc_to_2 = 1'b0;
    logic [3:0]        spin_angle;
    logic              spin_dir;
    logic              spin_busy;

    int errors = 0;
    int checks = 0;

    localparam int RST = 0, STB = 1, TCK = 2, BTN = 3, ANA = 4;

    typedef struct {
        int         op;
        int         val;
        logic [3:0] ang;
        logic       dir;
        logic       busy;
    } vec_t;

    vec_t vt[$];

    int m_p, m_ang, m_dir, m_mode, m_cnt;
    bit m_tick, m_ctcq;

    always #5 clock_40 = ~clock_40;

    analog_spinner dut (
        .clock_40    (clock_40),
        .reset_n     (reset_n),
        .mouse_strobe(mouse_strobe),
        .mouse_x     (mouse_x),
        .ana_x       (ana_x),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_acc     (btn_acc),
        .ctc_zc_to_2 (ctc_zc_to_2),
        .spin_angle  (spin_angle),
        .spin_dir    (spin_dir),
        .spin_busy   (spin_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int a, input int d, input int b);
        check({tag, " angle"}, int'(spin_angle), a);
        check({tag, " dir"}, int'(spin_dir), d);
        check({tag, " busy"}, int'(spin_busy), b);
    endtask

    task automatic add(input int op, input int val, input int a, input int d, input int b);
        vec_t v;
        v.op = op; v.val = val; v.ang = 4'(a); v.dir = d[0]; v.busy = b[0];
        vt.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mouse_strobe = 1'b0; mouse_x = '0; ana_x = '0; ctc_zc_to_2 = 1'b0;
        {btn_acc, btn_right, btn_left} = 3'b000;
        repeat (3) @(negedge clock_40);
        reset_n = 1'b1;
    endtask

    task automatic strobe(input int v);
        mouse_strobe = 1'b1;
        mouse_x = 9'(v);
        @(negedge clock_40);
        mouse_strobe = 1'b0;
    endtask

    task automatic tick1();
        ctc_zc_to_2 = 1'b1;
        @(negedge clock_40);
        ctc_zc_to_2 = 1'b0;
        @(negedge clock_40);
    endtask

    // Reference: one posedge worth of spinner behaviour from the current inputs
    task automatic model_clock();
        int d, a, mag, want;
        d = 0;
        if (mouse_strobe) d += int'(mouse_x);
        if (m_tick) begin
            a = (ana_x == -8'sd128) ? -127 : int'(ana_x);
            mag = a < 0 ? -a : a;
            if (mag > 16) d += (a < 0 ? -1 : 1) * ((mag - 16) / 8);
            if (btn_left != btn_right) begin
                m_cnt++;
                if (m_cnt >= (btn_acc ? 1 : 4)) begin
                    d += btn_right ? 4 : -4;
                    m_cnt = 0;
                end
            end else m_cnt = 0;
            want = m_p >= 4 ? 1 : m_p <= -4 ? -1 : 0;
            if (want == 0) m_mode = 0;
            else if (m_mode == -want) m_mode = 2;
            else begin
                m_ang = (m_ang + want + 16) % 16;
                m_dir = want > 0 ? 1 : 0;
                d -= 4 * want;
                m_mode = want;
            end
        end
        m_p += d;
        if (m_p > 2047) m_p = 2047;
        if (m_p < -2047) m_p = -2047;
        m_tick = ctc_zc_to_2 && !m_ctcq;
        m_ctcq = ctc_zc_to_2;
    endtask

    initial begin
        add(RST, 0, 0, 0, 0);   add(STB, 12, 0, 0, 1);
        add(TCK, 1, 1, 1, 1);   add(TCK, 1, 2, 1, 1);
        add(TCK, 1, 3, 1, 0);   add(TCK, 2, 3, 1, 0);
        add(STB, 52, 3, 1, 1);  add(TCK, 12, 15, 1, 1);
        add(TCK, 1, 0, 1, 0);   add(TCK, 1, 0, 1, 0);
        add(STB, -4, 0, 1, 1);  add(TCK, 1, 15, 0, 0);
        add(RST, 0, 0, 0, 0);   add(STB, 12, 0, 0, 1);
        add(TCK, 1, 1, 1, 1);   add(STB, -20, 1, 1, 1);
        add(TCK, 1, 1, 1, 1);   add(TCK, 1, 0, 0, 1);
        add(TCK, 1, 15, 0, 1);  add(TCK, 1, 14, 0, 0);
        add(TCK, 1, 14, 0, 0);
        add(RST, 0, 0, 0, 0);   add(BTN, 2, 0, 0, 0);
        add(TCK, 3, 0, 0, 0);   add(TCK, 1, 0, 0, 1);
        add(TCK, 8, 2, 1, 1);   add(BTN, 6, 2, 1, 1);
        add(TCK, 4, 6, 1, 1);   add(BTN, 3, 6, 1, 1);
        add(TCK, 4, 7, 1, 0);   add(BTN, 0, 7, 1, 0);
        add(RST, 0, 0, 0, 0);   add(ANA, 16, 0, 0, 0);
        add(TCK, 4, 0, 0, 0);   add(ANA, 17, 0, 0, 0);
        add(TCK, 2, 0, 0, 0);   add(ANA, 48, 0, 0, 0);
        add(TCK, 5, 4, 1, 1);   add(ANA, 0, 4, 1, 1);
        add(TCK, 1, 5, 1, 0);   add(ANA, -48, 5, 1, 0);
        add(TCK, 1, 5, 1, 1);   add(TCK, 1, 4, 0, 1);
        add(RST, 0, 0, 0, 0);   add(ANA, -128, 0, 0, 0);
        add(TCK, 1, 0, 0, 1);   add(TCK, 1, 15, 0, 1);
        add(RST, 0, 0, 0, 0);

        // Reset held with activity on every input
        @(negedge clock_40);
        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mouse_strobe = 1'b1; mouse_x = 9'sd100; ctc_zc_to_2 = ~ctc_zc_to_2;
            @(negedge clock_40);
        end
        check_out("in_reset", 0, 0, 0);
        mouse_strobe = 1'b0; ctc_zc_to_2 = 1'b0;
        @(negedge clock_40);
        reset_n = 1'b1;
        repeat (5) @(negedge clock_40);
        check_out("post_reset", 0, 0, 0);

        foreach (vt[i]) begin
            case (vt[i].op)
                RST:     do_reset();
                STB:     strobe(vt[i].val);
                TCK:     repeat (vt[i].val) tick1();
                BTN:     {btn_acc, btn_right, btn_left} = 3'(vt[i].val);
                default: ana_x = 8'(vt[i].val);
            endcase
            check_out($sformatf("row%0d", i), int'(vt[i].ang), int'(vt[i].dir), int'(vt[i].busy));
        end

        // Angle moves two clocks after the CTC level rises, not one
        do_reset();
        strobe(4);
        ctc_zc_to_2 = 1'b1;
        @(negedge clock_40);
        check("latency 1clk angle", int'(spin_angle), 0);
        ctc_zc_to_2 = 1'b0;
        @(negedge clock_40);
        check("latency 2clk angle", int'(spin_angle), 1);

        // Strobe lands on the same clock as the step
        do_reset();
        strobe(4);
        ctc_zc_to_2 = 1'b1;
        @(negedge clock_40);
        ctc_zc_to_2 = 1'b0;
        mouse_strobe = 1'b1; mouse_x = 9'sd4;
        @(negedge clock_40);
        mouse_strobe = 1'b0;
        check_out("simul", 1, 1, 1);
        check("simul pending", int'(dut.pending), 4);

        do_reset();
        repeat (40) strobe(255);
        check("sat pos pending", int'(dut.pending), 2047);
        check_out("sat pos", 0, 0, 1);
        do_reset();
        repeat (40) strobe(-256);
        check("sat neg pending", int'(dut.pending), -2047);

        do_reset();
        m_p = 0; m_ang = 0; m_dir = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_ctcq = 0;
        for (int i = 0; i < 3000; i++) begin
            check("rnd angle", int'(spin_angle), m_ang);
            check("rnd dir", int'(spin_dir), m_dir);
            check("rnd busy", int'(spin_busy), (m_p >= 4 || m_p <= -4) ? 1 : 0);
            mouse_strobe = ($urandom_range(3) == 0);
            mouse_x = 9'($urandom_range(511));
            if ($urandom_range(7) == 0) ana_x = 8'($urandom_range(255));
            if ($urandom_range(15) == 0) {btn_acc, btn_right, btn_left} = 3'($urandom_range(7));
            if ($urandom_range(2) == 0) ctc_zc_to_2 = ~ctc_zc_to_2;
            model_clock();
            @(negedge clock_40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
